lpc_frame_sequencer: RTL

//  Frame-level controller for the LPC encoder datapath, in the d_clk domain.
//  - Counts valid input samples into frames.
//  - At each frame boundary: clears the autocorrelator, then resets and starts the Levinson-Durbin solver.
//  - Waits for the solver's done flag (with timeout) and latches A0..A10 into a holding register.
//  - Presents the coefficients to the downstream packer/Avalon reader over a valid/ready handshake.

---
 rtl/lpc_pkg.sv | 23 ++
 rtl/lpc_coef_holdreg.sv | 42 ++++
 rtl/lpc_frame_sequencer.sv | 133 +++++++++++++
 3 files changed

// File: rtl/lpc_pkg.sv
// rtl/lpc_pkg.sv - shared constants, state encoding and coefficient packing for the LPC frame sequencer
package lpc_pkg;

  localparam int NCOEF     = 11;
  localparam int CW        = 16;
  localparam int MIN_FRAME = 16;
  localparam int TIMEOUT   = 4095;
  localparam int TW        = 12;

  typedef enum logic [2:0] {IDLE, ACCUM, RST, START, WAIT} lpc_state_e;

  typedef logic [NCOEF*CW-1:0] coef_vec_t;

  // A0 sits in the lowest CW bits of the packed vector
  function automatic logic signed [CW-1:0] coef_at(input coef_vec_t v, input int idx);
    return v[idx*CW +: CW];
  endfunction

  function automatic logic [15:0] clamp_len(input logic [15:0] len);
    return (len < 16'(MIN_FRAME)) ? 16'(MIN_FRAME) : len;
  endfunction

endpackage

// File: rtl/lpc_coef_holdreg.sv
// rtl/lpc_coef_holdreg.sv - single-entry valid/ready holding register for a packed coefficient set
module lpc_coef_holdreg
  import lpc_pkg::*;
(
  input  logic      d_clk,
  input  logic      rst,
  input  logic      cap_i,
  input  coef_vec_t cap_data_i,
  input  logic      ready_i,
  output coef_vec_t data_o,
  output logic      valid_o,
  output logic      accept_o,
  output logic      drop_o
);

  coef_vec_t data_q, data_d;
  logic      valid_q, valid_d;
  logic      hs;

  // A capture may reuse the slot being drained in the same cycle
  always_comb begin
    hs       = valid_q && ready_i;
    accept_o = cap_i && (!valid_q || hs);
    drop_o   = cap_i && valid_q && !hs;
    data_d   = accept_o ? cap_data_i : data_q;
    valid_d  = accept_o ? 1'b1 : (hs ? 1'b0 : valid_q);
  end

  always_ff @(posedge d_clk) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/lpc_frame_sequencer.sv
// rtl/lpc_frame_sequencer.sv - frame counter, solver sequencing and coefficient hand-off for the LPC encoder
module lpc_frame_sequencer
  import lpc_pkg::*;
(
  input  logic                d_clk,
  input  logic                rst,
  input  logic [15:0]         cfg_frame_len,
  input  logic                cfg_wr,
  input  logic                sample_v,
  output logic                corr_clr,
  output logic                ldr_rst,
  output logic                ldr_start,
  input  logic                ldr_done,
  input  logic [NCOEF*CW-1:0] ldr_a,
  output logic [NCOEF*CW-1:0] coef_data,
  output logic                coef_valid,
  input  logic                coef_ready,
  output logic [15:0]         frame_cnt,
  output logic                overrun,
  output logic                timeout,
  input  logic                err_clr
);

  lpc_state_e    state_q, state_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [15:0]   act_q, act_d;
  logic [15:0]   pend_q, pend_d;
  logic [15:0]   fcnt_q, fcnt_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          clr_q, clr_d;
  logic          ovr_q, ovr_d;
  logic          to_q, to_d;
  logic          boundary, busy, cap, to_ev, accept, drop;

  // Sample counting runs in every state so the next frame accumulates during a solve
  always_comb begin
    boundary = sample_v && (cnt_q == act_q - 16'd1);
    busy     = (state_q == RST) || (state_q == START) || (state_q == WAIT);
    cnt_d    = cnt_q;
    act_d    = act_q;
    pend_d   = pend_q;
    if (sample_v) cnt_d = boundary ? 16'd0 : cnt_q + 16'd1;
    if (boundary) act_d = pend_q;
    if (cfg_wr)   pend_d = clamp_len(cfg_frame_len);
  end

  always_comb begin
    state_d   = state_q;
    clr_d     = 1'b0;
    timer_d   = timer_q;
    cap       = 1'b0;
    to_ev     = 1'b0;
    ldr_rst   = 1'b0;
    ldr_start = 1'b0;
    unique case (state_q)
      IDLE:  if (sample_v) state_d = ACCUM;
      ACCUM: begin
        if (clr_q)         state_d = RST;
        else if (boundary) clr_d   = 1'b1;
      end
      RST: begin
        ldr_rst = 1'b1;
        state_d = START;
      end
      START: begin
        ldr_start = 1'b1;
        timer_d   = '0;
        state_d   = WAIT;
      end
      WAIT: begin
        if (ldr_done) begin
          cap     = 1'b1;
          state_d = ACCUM;
        end else if (timer_q == TW'(TIMEOUT)) begin
          to_ev   = 1'b1;
          state_d = ACCUM;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // New error events take priority over err_clr
  always_comb begin
    fcnt_d = accept ? fcnt_q + 16'd1 : fcnt_q;
    ovr_d  = (ovr_q && !err_clr) || drop || (boundary && busy);
    to_d   = (to_q && !err_clr) || to_ev;
  end

  always_ff @(posedge d_clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      act_q   <= 16'(MIN_FRAME);
      pend_q  <= 16'(MIN_FRAME);
      fcnt_q  <= '0;
      timer_q <= '0;
      clr_q   <= 1'b0;
      ovr_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      act_q   <= act_d;
      pend_q  <= pend_d;
      fcnt_q  <= fcnt_d;
      timer_q <= timer_d;
      clr_q   <= clr_d;
      ovr_q   <= ovr_d;
      to_q    <= to_d;
    end
  end

  lpc_coef_holdreg u_holdreg (
    .d_clk      (d_clk),
    .rst        (rst),
    .cap_i      (cap),
    .cap_data_i (ldr_a),
    .ready_i    (coef_ready),
    .data_o     (coef_data),
    .valid_o    (coef_valid),
    .accept_o   (accept),
    .drop_o     (drop)
  );

  assign corr_clr  = clr_q;
  assign frame_cnt = fcnt_q;
  assign overrun   = ovr_q;
  assign timeout   = to_q;

endmodule
